// File: rtl/mem_arb_pkg.sv
// Shared types for the unified RAM arbiter.
// State and requester encodings plus width defaults.
package mem_arb_pkg;

  localparam int ARB_AW = 7;
  localparam int ARB_DW = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and RAM signal bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dado;
  logic          mem_write;
  logic [DW-1:0] mem_saida;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_saida,
    output if_gnt, if_rdata, if_valid,
    output dm_gnt, dm_rdata, dm_valid,
    output mem_addr, mem_dado, mem_write
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_saida,
    input  if_gnt, if_rdata, if_valid,
    input  dm_gnt, dm_rdata, dm_valid,
    input  mem_addr, mem_dado, mem_write
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// ARB_RR_EN: round-robin on ties, else fixed dm>if.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    upd,
  input  logic    if_req,
  input  logic    dm_req,
  output req_id_e win,
  output logic    any_req
);

  assign any_req = if_req | dm_req;

`ifdef ARB_RR_EN
  req_id_e rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_last <= REQ_DM;
    else if (upd)
      rr_last <= win;
  end

  // on a tie the port not served last wins
  always_comb begin
    win = REQ_DM;
    unique case (1'b1)
      if_req & dm_req:
        win = (rr_last == REQ_DM) ? REQ_IF : REQ_DM;
      if_req & ~dm_req:
        win = REQ_IF;
      default:
        win = REQ_DM;
    endcase
  end
`else
  logic unused;
  assign unused = &{1'b0, clk, rst, upd};

  always_comb begin
    win = REQ_IF;
    unique case (1'b1)
      dm_req:  win = REQ_DM;
      default: win = REQ_IF;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port I/D RAM between fetch and load/store.
// Optional round-robin tie-break: define ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
)(
  input logic clk,
  input logic rst,
  mem_arb_if.slave bus
);

  arb_state_e    state_q, state_d;
  req_id_e       win, win_q;
  logic          any_req, take;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          if_valid_q, dm_valid_q;

  mem_arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .upd     (take),
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .win     (win),
    .any_req (any_req)
  );

  assign take = (state_q == ST_IDLE) & any_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // write strobe decoded from state so reset kills it at once
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.mem_write = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        bus.if_gnt    = (win_q == REQ_IF);
        bus.dm_gnt    = (win_q == REQ_DM);
        bus.mem_write = we_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= REQ_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      win_q   <= win;
      we_q    <= (win == REQ_DM) & bus.dm_we;
      addr_q  <= (win == REQ_DM) ? bus.dm_addr : bus.if_addr;
      wdata_q <= bus.dm_wdata;
    end
  end

  // RAM output settles on the mid-ACCESS negedge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if (state_q == ST_ACCESS) begin
        if (win_q == REQ_IF) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= bus.mem_saida;
        end else begin
          dm_valid_q <= 1'b1;
          if (!we_q) dm_rdata_q <= bus.mem_saida;
        end
      end
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_dado = wdata_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_valid = if_valid_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.dm_valid = dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [128];

  always @(posedge clk)
    if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_dado;

  always @(negedge clk)
    bus.mem_saida <= ram[bus.mem_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: per-cycle scheduled expectations
  bit          e_ifg [MAXC];
  bit          e_dmg [MAXC];
  bit          e_ifv [MAXC];
  bit          e_dmv [MAXC];
  bit          e_mw  [MAXC];
  logic [6:0]  e_ma  [MAXC];
  logic [31:0] e_md  [MAXC];
  bit          st_c  [MAXC];
  logic [6:0]  st_a  [MAXC];
  logic [31:0] st_d  [MAXC];
  bit          ld_if [MAXC];
  bit          ld_dm [MAXC];
  logic [31:0] ld_d  [MAXC];
  logic [31:0] refm  [128];
  logic [31:0] m_ifrd = '0;
  logic [31:0] m_dmrd = '0;
  int          m_free = 0;
  bit          m_last_dm = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_pick(bit ir, bit dr);
`ifdef ARB_RR_EN
    if (ir && dr) return !m_last_dm;
`endif
    return dr;
  endfunction

  task automatic clr(input int k);
    e_ifg[k] = 0; e_dmg[k] = 0;
    e_ifv[k] = 0; e_dmv[k] = 0;
    e_mw[k]  = 0; st_c[k]  = 0;
    ld_if[k] = 0; ld_dm[k] = 0;
  endtask

  task automatic model_eval(input bit r);
    int c;
    bit w;
    c = cyc;
    if (r) begin
      clr(c + 1);
      clr(c + 2);
      m_ifrd = '0;
      m_dmrd = '0;
      m_free = c + 1;
      m_last_dm = 1'b1;
    end else if (c >= m_free && (bus.if_req || bus.dm_req)) begin
      w = m_pick(bus.if_req, bus.dm_req);
      m_last_dm = w;
      m_free = c + 2;
      e_mw[c+1] = w & bus.dm_we;
      e_ma[c+1] = w ? bus.dm_addr : bus.if_addr;
      e_md[c+1] = bus.dm_wdata;
      if (w) begin
        e_dmg[c+1] = 1; e_dmv[c+2] = 1;
      end else begin
        e_ifg[c+1] = 1; e_ifv[c+2] = 1;
      end
      if (w && bus.dm_we) begin
        st_c[c+2] = 1;
        st_a[c+2] = bus.dm_addr;
        st_d[c+2] = bus.dm_wdata;
      end else begin
        ld_d[c+2] = refm[e_ma[c+1]];
        if (w) ld_dm[c+2] = 1;
        else   ld_if[c+2] = 1;
      end
    end
  endtask

  task automatic check_model();
    int c;
    c = cyc;
    if (st_c[c]) refm[st_a[c]] = st_d[c];
    if (ld_if[c]) m_ifrd = ld_d[c];
    if (ld_dm[c]) m_dmrd = ld_d[c];
    chk("ctl", {bus.if_gnt, bus.dm_gnt, bus.if_valid,
                bus.dm_valid, bus.mem_write},
        {e_ifg[c], e_dmg[c], e_ifv[c], e_dmv[c], e_mw[c]});
    chk("if_rdata", bus.if_rdata, m_ifrd);
    chk("dm_rdata", bus.dm_rdata, m_dmrd);
    if (e_ifg[c] || e_dmg[c])
      chk("mem_addr", bus.mem_addr, e_ma[c]);
    if (e_mw[c])
      chk("mem_dado", bus.mem_dado, e_md[c]);
    chk("excl_valid", bus.if_valid & bus.dm_valid, 0);
  endtask

  task automatic cyc_step(input bit r);
    rst = r;
    model_eval(r);
    @(posedge clk);
    #2;
    cyc++;
    check_model();
  endtask

  task automatic drive(input bit ir, input logic [6:0] ia,
                       input bit dr, input bit dw,
                       input logic [6:0] da, input logic [31:0] wd);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
  endtask

  typedef struct packed {
    bit          rst;
    bit          ir;
    logic [6:0]  ia;
    bit          dr;
    bit          dw;
    logic [6:0]  da;
    logic [31:0] wd;
    logic [3:0]  ectl;
    logic [31:0] eif;
    logic [31:0] edm;
  } vec_t;

  localparam logic [31:0] W0 = 32'h1C01_0037;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  vec_t        tbl [12];
  int          ng;
  logic [3:0]  pat;
  logic [3:0]  exp_pat;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] <= '0;
      refm[i] = '0;
    end
    ram[0]  <= W0;
    ram[55] <= 32'd1;
    ram[56] <= 32'd2;
    refm[0]  = W0;
    refm[55] = 32'd1;
    refm[56] = 32'd2;
    drive(0, 0, 0, 0, 0, 0);

    // ectl = {if_gnt, dm_gnt, if_valid, dm_valid} in the next cycle
    tbl[0]  = '{1, 0, 0,  0, 0, 0,  0,  4'b0000, 0,  0};
    tbl[1]  = '{0, 1, 0,  0, 0, 0,  0,  4'b1000, 0,  0};
    tbl[2]  = '{0, 0, 0,  0, 0, 0,  0,  4'b0010, W0, 0};
    tbl[3]  = '{0, 0, 0,  0, 0, 0,  0,  4'b0000, W0, 0};
    tbl[4]  = '{0, 0, 0,  1, 1, 60, DB, 4'b0100, W0, 0};
    tbl[5]  = '{0, 0, 0,  0, 0, 0,  0,  4'b0001, W0, 0};
    tbl[6]  = '{0, 0, 0,  1, 0, 60, 0,  4'b0100, W0, 0};
    tbl[7]  = '{0, 0, 0,  0, 0, 0,  0,  4'b0001, W0, DB};
`ifdef ARB_RR_EN
    tbl[8]  = '{0, 1, 0,  1, 0, 55, 0,  4'b1000, W0, DB};
    tbl[9]  = '{0, 0, 0,  1, 0, 55, 0,  4'b0010, W0, DB};
    tbl[10] = '{0, 0, 0,  1, 0, 55, 0,  4'b0100, W0, DB};
    tbl[11] = '{0, 0, 0,  0, 0, 0,  0,  4'b0001, W0, 1};
`else
    tbl[8]  = '{0, 1, 0,  1, 0, 55, 0,  4'b0100, W0, DB};
    tbl[9]  = '{0, 1, 0,  0, 0, 0,  0,  4'b0001, W0, 1};
    tbl[10] = '{0, 1, 0,  0, 0, 0,  0,  4'b1000, W0, 1};
    tbl[11] = '{0, 0, 0,  0, 0, 0,  0,  4'b0010, W0, 1};
`endif

    @(posedge clk);
    #2;
    chk("reset_ctl", {bus.if_gnt, bus.dm_gnt, bus.if_valid,
                      bus.dm_valid, bus.mem_write}, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_dado", bus.mem_dado, 0);

    // tests 1-3: directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr,
            tbl[i].dw, tbl[i].da, tbl[i].wd);
      cyc_step(tbl[i].rst);
      chk($sformatf("tbl%0d_ctl", i),
          {bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid},
          tbl[i].ectl);
      chk($sformatf("tbl%0d_ifrd", i), bus.if_rdata, tbl[i].eif);
      chk($sformatf("tbl%0d_dmrd", i), bus.dm_rdata, tbl[i].edm);
    end
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);

    // test 4: lone fetch first so a tie then starts with DM
    drive(1, 0, 0, 0, 0, 0);
    cyc_step(0);
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);
    cyc_step(0);
    drive(1, 1, 1, 0, 2, 0);
    ng  = 0;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      cyc_step(0);
      if (bus.dm_gnt || bus.if_gnt) begin
        ng++;
        pat = {pat[2:0], bus.dm_gnt};
      end
    end
`ifdef ARB_RR_EN
    exp_pat = 4'b1010;
`else
    exp_pat = 4'b1111;
`endif
    chk("t4_grants", ng, 4);
    chk("t4_order", pat, exp_pat);
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);
    cyc_step(0);

    // test 5: reset in the middle of a store
    drive(0, 0, 1, 1, 56, 5);
    cyc_step(0);
    chk("t5_gnt", bus.dm_gnt, 1);
    chk("t5_mw_pre", bus.mem_write, 1);
    drive(0, 0, 0, 0, 0, 0);
    model_eval(1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_mw_async", bus.mem_write, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    cyc++;
    check_model();
    chk("t5_no_valid", bus.dm_valid, 0);
    cyc_step(0);
    drive(0, 0, 1, 0, 56, 0);
    cyc_step(0);
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);
    chk("t5_valid", bus.dm_valid, 1);
    chk("t5_load56", bus.dm_rdata, 2);

    // test 6: top address then 0 with fetch req held past gnt
    drive(1, 127, 0, 0, 0, 0);
    cyc_step(0);
    chk("t6_gnt0", bus.if_gnt, 1);
    chk("t6_addr127", bus.mem_addr, 127);
    bus.if_addr = 7'd0;
    cyc_step(0);
    chk("t6_valid0", bus.if_valid, 1);
    chk("t6_data127", bus.if_rdata, 0);
    cyc_step(0);
    chk("t6_gnt1", bus.if_gnt, 1);
    chk("t6_addr0", bus.mem_addr, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);
    chk("t6_data0", bus.if_rdata, W0);

    // random traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) != 0, 7'($urandom),
            $urandom_range(0, 2) != 0, 1'($urandom),
            7'($urandom), $urandom);
      cyc_step($urandom_range(0, 299) == 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    cyc_step(0);
    cyc_step(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
